// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - fetch/data master arbiter for the single MIPS memory bus
// Optional round-robin arbitration under contention: define MIPS_ARB_RR_EN.
module mips_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic                mem_waitrequest,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   last_d, last_d_nxt;
    logic   i_req, d_req, grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef MIPS_ARB_RR_EN
    // Under contention the master that was not served last wins.
    assign grant_d = d_req & (~i_req | ~last_d);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_d_nxt     = last_d;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        i_waitrequest  = 1'b1;
        i_readdata     = '0;
        d_waitrequest  = 1'b1;
        d_readdata     = '0;
        case (state)
            IDLE: begin
                if (grant_d)    state_nxt = GNT_D;
                else if (i_req) state_nxt = GNT_I;
            end
            GNT_I: begin
                mem_address    = i_address;
                mem_read       = i_read;
                mem_byteenable = '1;
                if (!mem_waitrequest) begin
                    i_waitrequest = 1'b0;
                    i_readdata    = mem_readdata;
                    state_nxt     = IDLE;
                    last_d_nxt    = 1'b0;
                end
            end
            GNT_D: begin
                // A simultaneous read and write is treated as a write.
                mem_address    = d_address;
                mem_write      = d_write;
                mem_read       = d_read & ~d_write;
                mem_writedata  = d_writedata;
                mem_byteenable = d_byteenable;
                if (!mem_waitrequest) begin
                    d_waitrequest = 1'b0;
                    d_readdata    = mem_readdata;
                    state_nxt     = IDLE;
                    last_d_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed and randomized checks of mips_mem_arbiter
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_address, d_address, d_writedata, mem_address, mem_writedata;
    logic [31:0] i_readdata, d_readdata, mem_readdata;
    logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest;
    logic [3:0]  d_byteenable, mem_byteenable;
    logic        mem_read, mem_write, mem_waitrequest, busy;

    int checks = 0;
    int errors = 0;

`ifdef MIPS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) o[8*b +: 8] = w[8*b +: 8];
        return o;
    endfunction

    task automatic idle_masters();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_masters();
        mem_waitrequest = 1'b0;
        mem_readdata = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // Transaction-level model for the random phase: who owns the bus and the memory image.
    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];
    int          owner;          // 0 none, 1 fetch, 2 data
    bit          last_was_d;
    bit          i_active, d_active, i_fin, d_fin;
    bit          done;
    int          op;
    logic [31:0] exp_rd;
    logic [3:0]  idx;

    initial begin
        // Reset state, checked while reset is held
        rst_n = 1'b0;
        idle_masters();
        mem_waitrequest = 1'b1;
        mem_readdata = 32'hA5A5A5A5;
        #3;
        check("rst_busy", busy, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_mem_be", mem_byteenable, 0);
        check("rst_i_wait", i_waitrequest, 1);
        check("rst_d_wait", d_waitrequest, 1);
        do_reset();

        // Data read, zero-wait memory
        d_read = 1'b1; d_address = 32'h100;
        mem_waitrequest = 1'b0; mem_readdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_idle_mem_read", mem_read, 0);
        check("t1_idle_d_wait", d_waitrequest, 1);
        tick(); @(negedge clk);
        check("t1_mem_read", mem_read, 1);
        check("t1_mem_address", mem_address, 32'h100);
        check("t1_d_wait", d_waitrequest, 0);
        check("t1_d_readdata", d_readdata, 32'hDEADBEEF);
        check("t1_i_wait", i_waitrequest, 1);
        check("t1_i_readdata", i_readdata, 0);
        tick(); d_read = 1'b0; @(negedge clk);
        check("t1_after_busy", busy, 0);
        check("t1_after_mem_read", mem_read, 0);

        // Fetch read with three wait cycles
        i_read = 1'b1; i_address = 32'hBFC00000; mem_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); @(negedge clk);
            check("t2_wait_i_wait", i_waitrequest, 1);
            check("t2_wait_busy", busy, 1);
            check("t2_wait_mem_read", mem_read, 1);
            check("t2_wait_mem_write", mem_write, 0);
            check("t2_wait_be", mem_byteenable, 4'hF);
            check("t2_wait_addr", mem_address, 32'hBFC00000);
        end
        tick(); mem_waitrequest = 1'b0; mem_readdata = 32'h3C1DBFC0; @(negedge clk);
        check("t2_i_wait", i_waitrequest, 0);
        check("t2_i_readdata", i_readdata, 32'h3C1DBFC0);
        check("t2_mem_write", mem_write, 0);
        check("t2_be", mem_byteenable, 4'hF);
        tick(); i_read = 1'b0;

        // Data write with partial byte lanes
        d_write = 1'b1; d_address = 32'h20; d_writedata = 32'h12345678; d_byteenable = 4'b0011;
        @(negedge clk);
        check("t3_idle_wdata", mem_writedata, 0);
        tick(); @(negedge clk);
        check("t3_mem_write", mem_write, 1);
        check("t3_mem_read", mem_read, 0);
        check("t3_wdata", mem_writedata, 32'h12345678);
        check("t3_be", mem_byteenable, 4'b0011);
        check("t3_addr", mem_address, 32'h20);
        check("t3_d_wait", d_waitrequest, 0);
        tick(); idle_masters();

        // Continuous contention from a fresh reset
        do_reset();
        i_read = 1'b1; i_address = 32'h40; d_read = 1'b1; d_address = 32'h80;
        mem_waitrequest = 1'b0; mem_readdata = 32'h0BADF00D;
        for (int c = 1; c <= 8; c++) begin
            tick(); @(negedge clk);
            if (c % 2 == 1) begin
                bit exp_d;
                exp_d = RR ? (((c - 1) / 2) % 2 == 0) : 1'b1;
                check("t4_busy_gnt", busy, 1);
                check("t4_d_wait", d_waitrequest, !exp_d);
                check("t4_i_wait", i_waitrequest, exp_d);
            end else begin
                check("t4_busy_gap", busy, 0);
                check("t4_gap_d_wait", d_waitrequest, 1);
            end
        end
        tick(); idle_masters();

        // Asynchronous reset in the middle of a data grant
        d_read = 1'b1; d_address = 32'h44; mem_waitrequest = 1'b1;
        tick(); @(negedge clk);
        check("t5_pre_mem_read", mem_read, 1);
        check("t5_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_mem_read", mem_read, 0);
        check("t5_rst_mem_write", mem_write, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_d_wait", d_waitrequest, 1);
        tick(); rst_n = 1'b1; mem_waitrequest = 1'b0; mem_readdata = 32'hCAFE0001;
        @(negedge clk);
        check("t5_rel_busy", busy, 0);
        tick(); @(negedge clk);
        check("t5_fresh_mem_read", mem_read, 1);
        check("t5_fresh_d_wait", d_waitrequest, 0);
        check("t5_fresh_rdata", d_readdata, 32'hCAFE0001);
        tick(); idle_masters();

        // Simultaneous read and write on the data port
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h8; d_writedata = 32'h55AA55AA;
        d_byteenable = 4'hF;
        tick(); @(negedge clk);
        check("t6_mem_write", mem_write, 1);
        check("t6_mem_read", mem_read, 0);
        check("t6_wdata", mem_writedata, 32'h55AA55AA);
        tick(); idle_masters();

        // Randomized traffic against the transaction-level model
        for (int w = 0; w < 16; w++) begin
            slave_mem[w] = $urandom;
            ref_mem[w]   = slave_mem[w];
        end
        do_reset();
        owner = 0; last_was_d = 1'b0;
        i_active = 1'b0; d_active = 1'b0; i_fin = 1'b0; d_fin = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (i_active && i_fin) begin i_active = 1'b0; i_read = 1'b0; end
            if (d_active && d_fin) begin d_active = 1'b0; d_read = 1'b0; d_write = 1'b0; end
            if (!i_active && $urandom_range(0, 2) == 0) begin
                i_active = 1'b1; i_read = 1'b1;
                i_address = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_active && $urandom_range(0, 2) == 0) begin
                d_active = 1'b1;
                op = $urandom_range(0, 3);
                d_read = (op != 1); d_write = (op >= 1 && op != 3);
                d_address = 32'($urandom_range(0, 15)) << 2;
                d_writedata = $urandom;
                d_byteenable = 4'($urandom_range(0, 15));
            end
            mem_waitrequest = ($urandom_range(0, 2) == 0);
            #1 mem_readdata = slave_mem[mem_address[5:2]];
            @(negedge clk);

            i_fin = 1'b0; d_fin = 1'b0;
            done = (owner != 0) && !mem_waitrequest;
            check("r_busy", busy, owner != 0);
            if (owner == 0) begin
                check("r_idle_read", mem_read, 0);
                check("r_idle_write", mem_write, 0);
                check("r_idle_addr", mem_address, 0);
                check("r_idle_i_wait", i_waitrequest, 1);
                check("r_idle_d_wait", d_waitrequest, 1);
            end else if (owner == 1) begin
                idx = i_address[5:2];
                exp_rd = done ? ref_mem[idx] : 32'h0;
                check("r_i_addr", mem_address, i_address);
                check("r_i_read", mem_read, 1);
                check("r_i_write", mem_write, 0);
                check("r_i_be", mem_byteenable, 4'hF);
                check("r_i_wait", i_waitrequest, !done);
                check("r_i_rdata", i_readdata, exp_rd);
                check("r_i_d_wait", d_waitrequest, 1);
                i_fin = done;
            end else begin
                idx = d_address[5:2];
                exp_rd = done ? ref_mem[idx] : 32'h0;
                check("r_d_addr", mem_address, d_address);
                check("r_d_read", mem_read, d_read && !d_write);
                check("r_d_write", mem_write, d_write);
                check("r_d_wdata", mem_writedata, d_writedata);
                check("r_d_be", mem_byteenable, d_byteenable);
                check("r_d_wait", d_waitrequest, !done);
                check("r_d_rdata", d_readdata, exp_rd);
                check("r_d_i_wait", i_waitrequest, 1);
                d_fin = done;
                if (done && d_write) ref_mem[idx] = merge(ref_mem[idx], d_writedata, d_byteenable);
            end

            if (mem_write && !mem_waitrequest)
                slave_mem[mem_address[5:2]] = merge(slave_mem[mem_address[5:2]],
                                                    mem_writedata, mem_byteenable);

            if (owner == 0) begin
                if ((d_read || d_write) && !(RR && i_read && last_was_d)) owner = 2;
                else if (i_read) owner = 1;
            end else if (done) begin
                last_was_d = (owner == 2);
                owner = 0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
